// File: rtl/regfile_scoreboard.sv
// Purpose : 32x32 register file with per-register busy scoreboard and hazard stall.
// Latency : reads combinational with same-cycle writeback bypass; writes/busy/count 1 cycle.
// Backpressure: Stall blocks issue on RAW/WAW hazards; writeback is never blocked.
//
// Ports:
//   Clk, Rst               clock, synchronous active-low reset
//   ReadReg1/2, ReadData1/2  decode-side source reads (combinational, bypassed)
//   IssueValid/Writes/Dest   decode-side issue request; Stall blocks it
//   RegWrite/WriteReg/Data   writeback port; clears busy on the written register
//   PendingCount           registered count of busy registers
//   ErrWb                  one-cycle pulse: last cycle wrote a register that was not busy
module regfile_scoreboard #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREG   = 32
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    input  logic              IssueValid,
    input  logic              IssueWrites,
    input  logic [ADDR_W-1:0] IssueDest,
    output logic              Stall,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    output logic [ADDR_W:0]   PendingCount,
    output logic              ErrWb
);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [NREG-1:0]   busy_q, busy_d;
    logic [ADDR_W:0]   pend_q, pend_d;
    logic              err_q, err_d;

    logic wr_en;
    logic issue_set;

    // r0 is hardwired: it never takes a write and never becomes busy.
    assign wr_en = RegWrite && (WriteReg != '0);

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
        if (a == '0)
            return '0;
        else if (RegWrite && (WriteReg == a))
            return WriteData;
        else
            return regs_q[a];
    endfunction

    // A writeback landing this cycle resolves the hazard on its register.
    function automatic logic haz(input logic [ADDR_W-1:0] r);
        return busy_q[r] && (r != '0) && !(RegWrite && (WriteReg == r));
    endfunction

    assign ReadData1 = read_port(ReadReg1);
    assign ReadData2 = read_port(ReadReg2);

    // Both sources are always checked, even if the instruction ignores them.
    assign Stall = IssueValid &&
                   (haz(ReadReg1) || haz(ReadReg2) || (IssueWrites && haz(IssueDest)));

    assign issue_set = IssueValid && !Stall && IssueWrites && (IssueDest != '0);

    always_comb begin
        busy_d = busy_q;
        if (wr_en)
            busy_d[WriteReg] = 1'b0;
        // Set is applied after clear so a new producer wins over a retiring one.
        if (issue_set)
            busy_d[IssueDest] = 1'b1;
        busy_d[0] = 1'b0;

        pend_d = '0;
        for (int i = 0; i < NREG; i++)
            pend_d = pend_d + {{ADDR_W{1'b0}}, busy_d[i]};

        err_d = wr_en && !busy_q[WriteReg];
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            for (int i = 0; i < NREG; i++)
                regs_q[i] <= '0;
            busy_q <= '0;
            pend_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (wr_en)
                regs_q[WriteReg] <= WriteData;
            busy_q <= busy_d;
            pend_q <= pend_d;
            err_q  <= err_d;
        end
    end

    assign PendingCount = pend_q;
    assign ErrWb        = err_q;

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Consumer end of the 5-bit destination-register select path: takes the 5-bit write address chosen upstream and decodes it into one of 32 registers.
- Combines a 32x32 register file with a per-register busy scoreboard.
- Sits between decode (read/issue side) and writeback (write/clear side); raises Stall on RAW/WAW hazards.
- Provides write-to-read bypass so same-cycle writeback data is visible to decode.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- NREG, 32, number of registers (must equal 2**ADDR_W)

Ports:
- Clk  in  1  system clock, all state updates on rising edge
- Rst  in  1  reset, synchronous, active-low
- ReadReg1  in  ADDR_W  source register A address (decode)
- ReadReg2  in  ADDR_W  source register B address (decode)
- ReadData1  out  DATA_W  register A data, combinational
- ReadData2  out  DATA_W  register B data, combinational
- IssueValid  in  1  decode presents an instruction this cycle
- IssueWrites  in  1  issuing instruction will write IssueDest
- IssueDest  in  ADDR_W  destination register of issuing instruction
- Stall  out  1  issue blocked this cycle, combinational
- RegWrite  in  1  writeback valid
- WriteReg  in  ADDR_W  writeback destination
- WriteData  in  DATA_W  writeback data
- PendingCount  out  ADDR_W+1  number of busy registers, registered
- ErrWb  out  1  one-cycle pulse: previous cycle wrote a register that was not busy

Behaviour:
- Reset: Rst=0 sampled at posedge clears all registers to 0, all busy bits to 0, PendingCount=0, ErrWb=0. Reset overrides any concurrent write or issue. Reset mid-operation discards all pending state.
- Register 0: reads always return 0; writes are ignored; never marked busy; never causes a hazard.
- Write: at posedge, if RegWrite=1 and WriteReg!=0: reg[WriteReg]<=WriteData and busy[WriteReg] is cleared. Latency: 1 cycle to the array; 0 cycles to readers via bypass.
- Read (combinational): ReadDataN = 0 if ReadRegN==0. Otherwise WriteData if RegWrite=1 and WriteReg==ReadRegN. Otherwise reg[ReadRegN].
- Hazard term haz(r) = busy[r] & (r!=0) & !(RegWrite & WriteReg==r). A same-cycle writeback resolves the hazard.
- Stall = IssueValid & (haz(ReadReg1) | haz(ReadReg2) | (IssueWrites & haz(IssueDest))). Sources are checked even for instructions that do not use them; this is conservative by design.
- Issue accept: IssueValid=1 and Stall=0. If also IssueWrites=1 and IssueDest!=0, busy[IssueDest] is set at posedge.
- Simultaneous clear and set on the same register (writeback of r plus accepted issue to r): set wins; busy[r]=1 after the edge.
- ErrWb: registered; equals RegWrite & WriteReg!=0 & !busy[WriteReg], sampled pre-edge. The write still occurs.
- PendingCount: registered popcount of the next busy vector, range 0..31; it cannot reach 32 because of r0.
- No X propagation: all outputs are defined from the first cycle after reset.

Test Plan:
- Reset with Rst=0 for 2 cycles after random writes -> all reads return 0, PendingCount=0, Stall=0, ErrWb=0.
- Issue IssueDest=5 with IssueWrites=1 -> next cycle PendingCount=1. Issue with ReadReg1=5 -> Stall=1. Writeback WriteReg=5, WriteData=0xDEADBEEF in the same cycle -> Stall=0 and ReadData1=0xDEADBEEF (bypass). Next cycle PendingCount=0.
- Write 0x12345678 to reg 0 and issue IssueDest=0 -> ReadReg1=0 reads 0, PendingCount unchanged, no Stall.
- busy[7]=1; writeback reg 7 and accept an issue to dest 7 in the same cycle -> busy[7] remains 1, PendingCount unchanged, ErrWb=0.
- Writeback WriteReg=9 while not busy -> ErrWb=1 for exactly one cycle; reg 9 updated.
- Issue 31 distinct dests (1..31) back-to-back -> PendingCount=31. Issue with IssueDest=3 (WAW) -> Stall=1. Assert Rst=0 mid-sequence -> all cleared on the next edge.
